vga_console: RTL

Character-stream front end for the VGA text display. Accepts bytes over a valid/ready handshake, keeps a cursor on the 12-row × 32-column block grid, and turns each byte into block-control writes (`vga_addr_v`, `vga_addr_h`, `vga_ctrl`, `vga_ctrl_en`) for the downstream VGA controller. It also handles control characters and line/screen clearing. It sits between the bus/UART character source and the VGA controller's block-control write port.

---
 rtl/vga_console.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vga_console.sv
// Character-stream front end for the VGA block grid: turns accepted bytes into
// block-control writes, tracks the cursor and runs line / full-screen clears.
module vga_console #(
  parameter int          ROWS  = 12,
  parameter int          COLS  = 32,
  parameter logic [31:0] BLANK = 32'h2000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic [8:0]  color_in,
  input  logic        clr_req,
  output logic [3:0]  vga_addr_v,
  output logic [4:0]  vga_addr_h,
  output logic [31:0] vga_ctrl,
  output logic        vga_ctrl_en,
  output logic [3:0]  cursor_v,
  output logic [4:0]  cursor_h,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LCLR, FCLR} state_t;

  localparam logic [3:0] LAST_ROW   = 4'(ROWS - 1);
  localparam logic [4:0] LAST_COL   = 5'(COLS - 1);
  localparam logic [8:0] LAST_ENTRY = 9'(ROWS * COLS - 1);

  state_t      state_q;
  logic [8:0]  sweep_q;
  logic [3:0]  cursor_v_q;
  logic [4:0]  cursor_h_q;
  logic        en_q;
  logic [3:0]  addr_v_q;
  logic [4:0]  addr_h_q;
  logic [31:0] ctrl_q;

  logic [3:0] rowNext;
  logic       printable;

  assign rowNext   = (cursor_v_q == LAST_ROW) ? 4'd0 : cursor_v_q + 4'd1;
  assign printable = (ch_data >= 8'h20) && (ch_data <= 8'h7E);

  assign ch_ready    = (state_q == IDLE) && !clr_req;
  assign busy        = (state_q != IDLE);
  assign vga_ctrl_en = en_q;
  assign vga_addr_v  = addr_v_q;
  assign vga_addr_h  = addr_h_q;
  assign vga_ctrl    = ctrl_q;
  assign cursor_v    = cursor_v_q;
  assign cursor_h    = cursor_h_q;

  // Reset lands in FCLR so the screen is wiped at power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FCLR;
      sweep_q    <= '0;
      cursor_v_q <= '0;
      cursor_h_q <= '0;
      en_q       <= 1'b0;
      addr_v_q   <= '0;
      addr_h_q   <= '0;
      ctrl_q     <= '0;
    end else begin
      en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= FCLR;
            sweep_q <= '0;
          end else if (ch_valid) begin
            if (printable) begin
              en_q     <= 1'b1;
              addr_v_q <= cursor_v_q;
              addr_h_q <= cursor_h_q;
              ctrl_q   <= {1'b0, ch_data[6:0], 15'b0, color_in};
              if (cursor_h_q == LAST_COL) begin
                cursor_h_q <= '0;
                cursor_v_q <= rowNext;
                state_q    <= LCLR;
                sweep_q    <= '0;
              end else begin
                cursor_h_q <= cursor_h_q + 5'd1;
              end
            end else begin
              case (ch_data)
                8'h0A: begin
                  cursor_h_q <= '0;
                  cursor_v_q <= rowNext;
                  state_q    <= LCLR;
                  sweep_q    <= '0;
                end
                8'h0D: cursor_h_q <= '0;
                // Backspace blanks the cell it lands on; at the origin it is a no-op.
                8'h08: begin
                  if (cursor_h_q != 5'd0) begin
                    cursor_h_q <= cursor_h_q - 5'd1;
                    en_q       <= 1'b1;
                    addr_v_q   <= cursor_v_q;
                    addr_h_q   <= cursor_h_q - 5'd1;
                    ctrl_q     <= BLANK;
                  end else if (cursor_v_q != 4'd0) begin
                    cursor_v_q <= cursor_v_q - 4'd1;
                    cursor_h_q <= LAST_COL;
                    en_q       <= 1'b1;
                    addr_v_q   <= cursor_v_q - 4'd1;
                    addr_h_q   <= LAST_COL;
                    ctrl_q     <= BLANK;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        LCLR: begin
          en_q     <= 1'b1;
          addr_v_q <= cursor_v_q;
          addr_h_q <= sweep_q[4:0];
          ctrl_q   <= BLANK;
          sweep_q  <= sweep_q + 9'd1;
          if (sweep_q[4:0] == LAST_COL) state_q <= IDLE;
        end
        FCLR: begin
          en_q     <= 1'b1;
          addr_v_q <= sweep_q[8:5];
          addr_h_q <= sweep_q[4:0];
          ctrl_q   <= BLANK;
          if (sweep_q == LAST_ENTRY) begin
            state_q    <= IDLE;
            sweep_q    <= '0;
            cursor_v_q <= '0;
            cursor_h_q <= '0;
          end else begin
            sweep_q <= sweep_q + 9'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
